cache_tester: RTL and testbench

- Parametrised memory exerciser that drives the cache request port: it replaces the hand-coded board-level poke loop.
- It writes a programmable data pattern over an address window, reads the window back, and compares each word.
- It reports pass/fail, an error count, first-failure details and an LED summary.
- It sits between the top level and the cache and uses the existing cache handshake (address, data_in, write_enable, data_out, data_out_ready, busy).

---
 rtl/cache_tester_pkg.sv | 27 ++
 rtl/cache_tester_if.sv | 26 ++
 rtl/cache_tester_pattern_gen.sv | 47 ++++
 rtl/cache_tester.sv | 213 +++++++++++++++++++++
 tb/tb_cache_tester.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_tester_pkg.sv
// Shared types and constants for the cache exerciser: FSM encoding, pattern
// mode selectors and the LFSR polynomial.
package cache_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_WR_ISSUE   = 3'd2,
    S_WR_WAIT    = 3'd3,
    S_RD_ISSUE   = 3'd4,
    S_RD_WAIT    = 3'd5,
    S_NEXT_PASS  = 3'd6,
    S_DONE       = 3'd7
  } state_e;

  localparam int PATTERN_ADDR  = 0;
  localparam int PATTERN_NADDR = 1;
  localparam int PATTERN_LFSR  = 2;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/cache_tester_if.sv
// Cache request port shared by the exerciser (master) and the cache (slave).
interface cache_tester_if #(
  parameter int ADDR_WIDTH = 32
) ();
  // Handshake: the master holds address, data_in and write_enable stable
  // until the access completes. A write (write_enable = 4'b1111) completes on
  // the first cycle busy is low; a read (write_enable = 0) completes on the
  // first cycle data_out_ready is high and busy is low, and data_out is then
  // the word at the held address.
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           data_in;
  logic [3:0]            write_enable;
  logic [31:0]           data_out;
  logic                  data_out_ready;
  logic                  busy;

  modport master (
    output address, data_in, write_enable,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  address, data_in, write_enable,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/cache_tester_pattern_gen.sv
// Test data generator: address, inverted address, or a Galois LFSR that is
// reloaded at the start of each phase so write and read streams line up.
module cache_tester_pattern_gen
  import cache_tester_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          PATTERN_MODE = 0,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  output logic [31:0]           pattern_o
);

  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] addr_word;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    addr_word = 32'(address_i);
    case (PATTERN_MODE)
      PATTERN_NADDR: pattern_o = ~addr_word;
      PATTERN_LFSR:  pattern_o = lfsr_q;
      default:       pattern_o = addr_word;
    endcase
  end

endmodule

// File: rtl/cache_tester.sv
// Memory exerciser: writes a pattern over an address window through the cache,
// reads it back, and reports mismatches, timeouts and an LED summary.
module cache_tester
  import cache_tester_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WORD_COUNT     = 16,
  parameter int                    STRIDE         = 4,
  parameter int                    PATTERN_MODE   = 0,
  parameter logic [31:0]           LFSR_SEED      = 32'hACE1_0001,
  parameter int                    ITERATIONS     = 1,
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  cache_tester_if.master        cache,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [31:0]           first_fail_data,
  output logic [5:0]            led,
  output state_e                dbg_state_o
);

  localparam int          IDX_W      = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] ITER_LIMIT = 32'(ITERATIONS);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [31:0]           pass_cnt_q, pass_cnt_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            we_q, we_d;
  logic [15:0]           err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic [31:0]           ffd_q, ffd_d;

  logic                  pat_load, pat_step;
  logic [31:0]           pattern;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_word, tmo_expired;

  assign cur_addr    = BASE_ADDR + ADDR_WIDTH'(index_q) * ADDR_WIDTH'(STRIDE);
  assign last_word   = (index_q == IDX_W'(WORD_COUNT - 1));
  assign tmo_expired = ((tmo_q + 32'd1) >= TMO_LIMIT);

  cache_tester_pattern_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PATTERN_MODE(PATTERN_MODE),
    .LFSR_SEED   (LFSR_SEED)
  ) u_pattern (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pat_load),
    .step_i   (pat_step),
    .address_i(cur_addr),
    .pattern_o(pattern)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    pass_cnt_d = pass_cnt_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    ffa_d      = ffa_q;
    ffd_d      = ffd_q;
    pat_load   = 1'b0;
    pat_step   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (!cache.busy) begin
          err_d      = '0;
          timeout_d  = 1'b0;
          ffa_d      = '0;
          ffd_d      = '0;
          index_d    = '0;
          pass_cnt_d = '0;
          pat_load   = 1'b1;
          state_d    = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        addr_d  = cur_addr;
        wdata_d = pattern;
        we_d    = 4'hF;
        tmo_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (!cache.busy) begin
          we_d = '0;
          if (last_word) begin
            index_d  = '0;
            pat_load = 1'b1;
            state_d  = S_RD_ISSUE;
          end else begin
            index_d  = index_q + IDX_W'(1);
            pat_step = 1'b1;
            state_d  = S_WR_ISSUE;
          end
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          we_d      = '0;
          state_d   = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        addr_d  = cur_addr;
        we_d    = '0;
        tmo_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (cache.data_out_ready && !cache.busy) begin
          if (cache.data_out != pattern) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // A zero count means no earlier mismatch in this run.
            if (err_q == 16'd0) begin
              ffa_d = addr_q;
              ffd_d = cache.data_out;
            end
          end
          if (last_word) begin
            index_d = '0;
            state_d = S_NEXT_PASS;
          end else begin
            index_d  = index_q + IDX_W'(1);
            pat_step = 1'b1;
            state_d  = S_RD_ISSUE;
          end
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          we_d      = '0;
          state_d   = S_DONE;
        end
      end
      S_NEXT_PASS: begin
        pass_cnt_d = pass_cnt_q + 32'd1;
        if ((ITERATIONS != 0) && (pass_cnt_d == ITER_LIMIT)) begin
          state_d = S_DONE;
        end else begin
          index_d  = '0;
          pat_load = 1'b1;
          state_d  = S_WR_ISSUE;
        end
      end
      S_DONE: begin
        if (start) state_d = S_WAIT_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      pass_cnt_q <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      ffa_q      <= '0;
      ffd_q      <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      pass_cnt_q <= pass_cnt_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      ffa_q      <= ffa_d;
      ffd_q      <= ffd_d;
    end
  end

  assign cache.address      = addr_q;
  assign cache.data_in      = wdata_q;
  assign cache.write_enable = we_q;

  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == 16'd0) && !timeout_q;
  assign error_count     = err_q;
  assign timeout         = timeout_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;
  assign led             = {done, pass, timeout_q, err_q[2:0]};
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cache_tester.sv
// Directed bench: two exercisers (address pattern / LFSR x3) against small
// behavioural cache models with busy, corruption and stuck-busy knobs.
`timescale 1ns/1ps
module tb_cache_tester;
  import cache_tester_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  int checks = 0;
  int errors = 0;

  cache_tester_if #(.ADDR_WIDTH(32)) bus_a ();
  cache_tester_if #(.ADDR_WIDTH(32)) bus_b ();

  logic done_a, pass_a, to_a, done_b, pass_b, to_b;
  logic [15:0] err_a, err_b;
  logic [31:0] ffa_a, ffd_a, ffa_b, ffd_b;
  logic [5:0] led_a, led_b;
  state_e st_a, st_b;

  cache_tester #(.WORD_COUNT(16), .PATTERN_MODE(0), .ITERATIONS(1), .TIMEOUT_CYCLES(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cache(bus_a), .done(done_a), .pass(pass_a),
    .error_count(err_a), .timeout(to_a), .first_fail_addr(ffa_a), .first_fail_data(ffd_a),
    .led(led_a), .dbg_state_o(st_a));

  cache_tester #(.WORD_COUNT(32), .PATTERN_MODE(2), .ITERATIONS(3), .TIMEOUT_CYCLES(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cache(bus_b), .done(done_b), .pass(pass_b),
    .error_count(err_b), .timeout(to_b), .first_fail_addr(ffa_b), .first_fail_data(ffd_b),
    .led(led_b), .dbg_state_o(st_b));

  // Cache model A: optional corruption of 0x14, 10-cycle busy on new 16-byte lines, stuck busy.
  logic [31:0] mem_a [256];
  logic [31:0] rdata_a = 32'h0, raddr_a = 32'h0;
  logic rvalid_a = 1'b0;
  logic corrupt_a, busy_mode_a, stuck_a;
  int busy_cnt_a = 0;
  logic [7:0] last_line_a = 8'hFF;
  int wr_cnt_a = 0, rd_cnt_a = 0;
  wire new_line_a = busy_mode_a && (bus_a.write_enable != 4'h0) && (bus_a.address[11:4] != last_line_a);
  assign bus_a.busy = stuck_a || (busy_cnt_a != 0) || new_line_a;
  assign bus_a.data_out = rdata_a;
  assign bus_a.data_out_ready = rvalid_a && (raddr_a == bus_a.address) && (bus_a.write_enable == 4'h0);

  always @(posedge clk) begin
    if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
    else if (new_line_a) begin
      busy_cnt_a <= 9;
      last_line_a <= bus_a.address[11:4];
    end
    if (bus_a.write_enable == 4'hF && !bus_a.busy) begin
      mem_a[bus_a.address[9:2]] <= bus_a.data_in;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (st_a == S_RD_WAIT && bus_a.data_out_ready && !bus_a.busy) rd_cnt_a <= rd_cnt_a + 1;
    rdata_a  <= mem_a[bus_a.address[9:2]] ^ ((corrupt_a && bus_a.address == 32'h14) ? 32'h1 : 32'h0);
    raddr_a  <= bus_a.address;
    rvalid_a <= (bus_a.write_enable == 4'h0) && !bus_a.busy;
  end

  // Request stability monitor for A during wait states.
  int unstable_a = 0, busy_wr_a = 0, bad_we_a = 0;
  logic prev_wait_a = 1'b0;
  logic [31:0] p_addr_a = 32'h0, p_di_a = 32'h0;
  logic [3:0] p_we_a = 4'h0;
  always @(negedge clk) begin
    if (st_a == S_WR_WAIT || st_a == S_RD_WAIT) begin
      if (prev_wait_a && (bus_a.address != p_addr_a || bus_a.data_in != p_di_a ||
                          bus_a.write_enable != p_we_a)) unstable_a++;
      if (st_a == S_WR_WAIT && bus_a.busy) begin
        busy_wr_a++;
        if (bus_a.write_enable != 4'hF) bad_we_a++;
      end
      prev_wait_a = 1'b1;
      p_addr_a = bus_a.address;
      p_di_a   = bus_a.data_in;
      p_we_a   = bus_a.write_enable;
    end else begin
      prev_wait_a = 1'b0;
    end
  end

  // Cache model B: ideal, and checks both streams against the expected LFSR sequence.
  logic [31:0] mem_b [256];
  logic [31:0] exp_b [32];
  logic [31:0] rdata_b = 32'h0, raddr_b = 32'h0;
  logic rvalid_b = 1'b0;
  int wr_cnt_b = 0, rd_cnt_b = 0, wbad_b = 0, rbad_b = 0;
  assign bus_b.busy = 1'b0;
  assign bus_b.data_out = rdata_b;
  assign bus_b.data_out_ready = rvalid_b && (raddr_b == bus_b.address) && (bus_b.write_enable == 4'h0);

  always @(posedge clk) begin
    if (bus_b.write_enable == 4'hF) begin
      mem_b[bus_b.address[9:2]] <= bus_b.data_in;
      if (bus_b.data_in !== exp_b[wr_cnt_b % 32]) wbad_b <= wbad_b + 1;
      wr_cnt_b <= wr_cnt_b + 1;
    end
    if (st_b == S_RD_WAIT && bus_b.data_out_ready) begin
      if (bus_b.data_out !== exp_b[rd_cnt_b % 32]) rbad_b <= rbad_b + 1;
      rd_cnt_b <= rd_cnt_b + 1;
    end
    rdata_b  <= mem_b[bus_b.address[9:2]];
    raddr_b  <= bus_b.address;
    rvalid_b <= (bus_b.write_enable == 4'h0);
  end

  function automatic logic [31:0] tb_lfsr(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int budget, input string tag);
    int n = 0;
    while (!(sel_b ? done_b : done_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sel_b ? done_b : done_a, 1'b1);
  endtask

  int w0, r0, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    corrupt_a = 1'b0; busy_mode_a = 1'b0; stuck_a = 1'b0;
    exp_b[0] = 32'hACE1_0001;
    for (int i = 1; i < 32; i++) exp_b[i] = tb_lfsr(exp_b[i-1]);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", st_a, S_IDLE);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_err", err_a, 16'h0);
    check("rst_led", led_a, 6'b0);
    check("rst_we", bus_a.write_enable, 4'h0);
    check("rst_addr", bus_a.address, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Ideal cache, address pattern; a second start mid-run must be ignored
    w0 = wr_cnt_a; r0 = rd_cnt_a;
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    pulse_start(1'b0);
    wait_done(1'b0, 500, "ideal_done");
    check("ideal_pass", pass_a, 1'b1);
    check("ideal_err", err_a, 16'h0);
    check("ideal_led", led_a, 6'b110000);
    check("ideal_writes", wr_cnt_a - w0, 16);
    check("ideal_reads", rd_cnt_a - r0, 16);
    check("ideal_mem5", mem_a[5], 32'h14);
    check("ideal_mem15", mem_a[15], 32'h3C);

    // Corrupted read of 0x14
    corrupt_a = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 500, "corrupt_done");
    corrupt_a = 1'b0;
    check("corrupt_err", err_a, 16'd1);
    check("corrupt_ffa", ffa_a, 32'h14);
    check("corrupt_ffd", ffd_a, 32'h15);
    check("corrupt_pass", pass_a, 1'b0);
    check("corrupt_led", led_a, 6'b100001);

    // Busy for 10 cycles on each new line during writes
    busy_mode_a = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 1000, "busy_done");
    busy_mode_a = 1'b0;
    check("busy_pass", pass_a, 1'b1);
    check("busy_err_cleared", err_a, 16'h0);
    check("busy_wr_cycles", busy_wr_a, 40);
    check("busy_we_held", bad_we_a, 0);
    check("wait_stable", unstable_a, 0);

    // Stuck busy after the first write is issued
    pulse_start(1'b0);
    n = 0;
    while (st_a != S_WR_ISSUE && n < 50) begin @(negedge clk); n++; end
    check("reach_wr_issue", st_a, S_WR_ISSUE);
    stuck_a = 1'b1;
    n = 0;
    while (!to_a && n < 100) begin @(negedge clk); n++; end
    check("tmo_latency", n, 33);
    check("tmo_done", done_a, 1'b1);
    check("tmo_pass", pass_a, 1'b0);
    check("tmo_we", bus_a.write_enable, 4'h0);
    check("tmo_led", led_a, 6'b101000);
    stuck_a = 1'b0;

    // Reset during a read, then a clean run
    pulse_start(1'b0);
    n = 0;
    while (st_a != S_RD_WAIT && n < 200) begin @(negedge clk); n++; end
    check("reach_rd_wait", st_a, S_RD_WAIT);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", st_a, S_IDLE);
    check("midrst_we", bus_a.write_enable, 4'h0);
    check("midrst_addr", bus_a.address, 32'h0);
    check("midrst_data", bus_a.data_in, 32'h0);
    check("midrst_led", led_a, 6'b0);
    rst = 1'b0;
    @(negedge clk);
    w0 = wr_cnt_a;
    pulse_start(1'b0);
    wait_done(1'b0, 500, "post_rst_done");
    check("post_rst_pass", pass_a, 1'b1);
    check("post_rst_writes", wr_cnt_a - w0, 16);

    // LFSR pattern, 32 words, 3 passes
    pulse_start(1'b1);
    wait_done(1'b1, 2000, "lfsr_done");
    check("lfsr_pass", pass_b, 1'b1);
    check("lfsr_err", err_b, 16'h0);
    check("lfsr_writes", wr_cnt_b, 96);
    check("lfsr_reads", rd_cnt_b, 96);
    check("lfsr_wdata", wbad_b, 0);
    check("lfsr_rdata", rbad_b, 0);
    check("lfsr_mem0", mem_b[0], 32'hACE1_0001);
    check("lfsr_mem1", mem_b[1], 32'hD650_8003);
    check("lfsr_led", led_b, 6'b110000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
